// File: rtl/serout_sequencer.sv
// serout_sequencer: control sequencer for the POKEY serial-output path.
// Turns SEROUT writes into holding-register capture strobes, and baud ticks
// into load/shift strobes for one frame. Also keeps the "data needed",
// "output complete" and counter/shifter consistency status bits.
module serout_sequencer #(
    parameter int FRAME_BITS = 10,
    parameter int CNT_W      = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enp,
    input  logic serout_wr,
    input  logic bit_tick,
    input  logic shreg_empty,
    input  logic need_ack,
    output logic addr_dw,
    output logic load,
    output logic shift,
    output logic busy,
    output logic need_data,
    output logic seroc,
    output logic sync_err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter value while the stop bit is on the line (last bit of the frame).
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;
    logic             hold_full_q, hold_full_d;
    logic             need_q,      need_d;
    logic             seroc_q,     seroc_d;
    logic             sync_err_q,  sync_err_d;

    logic tick_s;
    logic wr_s;
    logic last_s;
    logic load_s;
    logic shift_s;
    logic finish_s;

    // The qualified tick and write events. Reset suppresses every strobe.
    assign tick_s = enp & bit_tick & ~reset;
    assign wr_s   = enp & serout_wr & ~reset;
    assign last_s = (bit_cnt_q == LAST_CNT);

    // State register: all sequencer state advances only on enabled phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= {CNT_W{1'b0}};
            hold_full_q <= 1'b0;
            need_q      <= 1'b0;
            seroc_q     <= 1'b0;
            sync_err_q  <= 1'b0;
        end else if (enp) begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_full_q <= hold_full_d;
            need_q      <= need_d;
            seroc_q     <= seroc_d;
            sync_err_q  <= sync_err_d;
        end else begin
            state_q     <= state_q;
            bit_cnt_q   <= bit_cnt_q;
            hold_full_q <= hold_full_q;
            need_q      <= need_q;
            seroc_q     <= seroc_q;
            sync_err_q  <= sync_err_q;
        end
    end

    // Output decode: the load/shift strobes. At the stop bit a waiting byte is
    // loaded in place of a shift, so back-to-back frames have no idle bit.
    always_comb begin
        load_s   = 1'b0;
        shift_s  = 1'b0;
        finish_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (tick_s && hold_full_q) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (tick_s && last_s) begin
                    load_s   = hold_full_q;
                    finish_s = ~hold_full_q;
                end else if (tick_s) begin
                    shift_s  = 1'b1;
                end else begin
                    shift_s  = 1'b0;
                end
            end
            default: begin
                load_s   = 1'b0;
                shift_s  = 1'b0;
                finish_s = 1'b0;
            end
        endcase
    end

    // Next-state logic for the frame FSM and its bit counter.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        if (load_s) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (finish_s) begin
            state_d   = ST_IDLE;
            bit_cnt_d = {CNT_W{1'b0}};
        end else if (shift_s) begin
            state_d   = ST_SHIFT;
            bit_cnt_d = bit_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            state_d   = state_q;
            bit_cnt_d = bit_cnt_q;
        end
    end

    // Status next-state: holding register, data-needed (set beats clear),
    // output-complete level and the sticky consistency error.
    always_comb begin
        hold_full_d = hold_full_q;
        need_d      = need_q;
        if (wr_s) begin
            hold_full_d = 1'b1;
        end else if (load_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end
        if (load_s && !wr_s) begin
            need_d = 1'b1;
        end else if (need_ack || wr_s) begin
            need_d = 1'b0;
        end else begin
            need_d = need_q;
        end
        seroc_d    = (state_d == ST_IDLE) & ~hold_full_d;
        sync_err_d = sync_err_q |
                     ((state_q == ST_SHIFT) & (bit_cnt_q < LAST_CNT) & shreg_empty);
    end

    assign addr_dw   = wr_s;
    assign load      = load_s;
    assign shift     = shift_s;
    assign busy      = (state_q == ST_SHIFT);
    assign need_data = need_q;
    assign seroc     = seroc_q;
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_serout_sequencer.sv
// Scoreboard bench for serout_sequencer: the driver predicts every cycle's
// outputs from a frame-level model and queues them; a monitor compares.
module tb_serout_sequencer;

    localparam int FRAME_BITS = 10;

    logic clk = 1'b0;
    logic reset, enp, serout_wr, bit_tick, shreg_empty, need_ack;
    logic addr_dw, load, shift, busy, need_data, seroc, sync_err;

    serout_sequencer #(.FRAME_BITS(FRAME_BITS), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .enp(enp), .serout_wr(serout_wr),
        .bit_tick(bit_tick), .shreg_empty(shreg_empty), .need_ack(need_ack),
        .addr_dw(addr_dw), .load(load), .shift(shift), .busy(busy),
        .need_data(need_data), .seroc(seroc), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v;    // level outputs are defined (not the very first reset cycle)
        logic ld, sh, ad, bz, nd, sc, se;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cycle  = 0;

    // Frame-level reference model
    bit m_busy = 1'b0;   // a frame is on the line
    int m_pos  = 0;      // ticks elapsed since the frame was loaded
    bit m_held = 1'b0;   // a byte waits in the holding register
    bit m_need = 1'b0;
    bit m_sc   = 1'b0;
    bit m_se   = 1'b0;
    bit m_known = 1'b0;

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got === exp) passes++;
        else begin
            fails++;
            $display("FAIL %s cycle=%0d got=%b expected=%b", name, cycle, got, exp);
        end
    endtask

    // One clock cycle of stimulus plus its predicted response.
    task automatic cyc(input bit r, input bit e, input bit w, input bit t,
                       input bit em, input bit ak);
        exp_t x;
        bit ld, sh, fin, wr;
        reset = r; enp = e; serout_wr = w; bit_tick = t;
        shreg_empty = em; need_ack = ak;
        ld = 1'b0; sh = 1'b0; fin = 1'b0;
        wr = !r && e && w;
        if (!r && e && t) begin
            if (!m_busy) ld = m_held;
            else if (m_pos == FRAME_BITS - 1) begin
                if (m_held) ld = 1'b1; else fin = 1'b1;
            end else sh = 1'b1;
        end
        x.v = m_known; x.ld = ld; x.sh = sh; x.ad = wr;
        x.bz = m_busy; x.nd = m_need; x.sc = m_sc; x.se = m_se;
        exp_q.push_back(x);
        if (r) begin
            m_busy = 1'b0; m_pos = 0; m_held = 1'b0;
            m_need = 1'b0; m_sc = 1'b0; m_se = 1'b0; m_known = 1'b1;
        end else if (e) begin
            if (m_busy && m_pos < FRAME_BITS - 1 && em) m_se = 1'b1;
            if (ld && !wr) m_need = 1'b1;
            else if (ak || wr) m_need = 1'b0;
            if (ld) begin m_busy = 1'b1; m_pos = 0; end
            else if (fin) begin m_busy = 1'b0; m_pos = 0; end
            else if (sh) m_pos = m_pos + 1;
            if (wr) m_held = 1'b1;
            else if (ld) m_held = 1'b0;
            m_sc = !m_busy && !m_held;
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic wr_byte();
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compare DUT outputs with the queued prediction each cycle.
    always @(negedge clk) begin
        exp_t x;
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("load", load, x.ld);
            chk("shift", shift, x.sh);
            chk("addr_dw", addr_dw, x.ad);
            if (x.v) begin
                chk("busy", busy, x.bz);
                chk("need_data", need_data, x.nd);
                chk("seroc", seroc, x.sc);
                chk("sync_err", sync_err, x.se);
            end
        end
    end

    initial begin
        reset = 1'b1; enp = 1'b0; serout_wr = 1'b0; bit_tick = 1'b0;
        shreg_empty = 1'b0; need_ack = 1'b0;
        @(posedge clk);
        #1;
        // Reset, then ticks with nothing to send
        do_reset();
        ticks(3);
        // Single frame, with a gated-off tick in the middle
        wr_byte();
        ticks(5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        ticks(7);
        // Back-to-back frames: second byte arrives mid-frame
        wr_byte();
        ticks(4);
        wr_byte();
        ticks(22);
        // Write coinciding with the load tick, then an ack
        wr_byte();
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        ticks(3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        ticks(20);
        // Reset in the middle of a frame
        wr_byte();
        ticks(5);
        do_reset();
        ticks(2);
        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(1'b0, ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0),
                ($urandom_range(0, 2) == 0), 1'b0, ($urandom_range(0, 9) == 0));
        end
        // Consistency error mid-frame stays set across later frames
        do_reset();
        wr_byte();
        ticks(4);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        ticks(8);
        wr_byte();
        ticks(12);
        do_reset();
        ticks(2);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) passes++;
        else begin
            fails++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
